assoc_cache_ctrl: RTL and testbench



---
 rtl/assoc_cache_ctrl_if.sv | 29 ++
 rtl/assoc_cache_ctrl.sv | 142 ++++++++++++++
 tb/tb_assoc_cache_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/assoc_cache_ctrl_if.sv
// Pipeline-side and memory-side bus of the 2-way set-associative data cache.
// slave: the cache itself; master: whatever drives the pipeline and memory side.
interface assoc_cache_ctrl_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              rd_en;
  logic              wr_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              freeze;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport slave (
    input  rd_en, wr_en, addr, wdata, mem_rdata, mem_ready,
    output rdata, freeze, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output rd_en, wr_en, addr, wdata, mem_rdata, mem_ready,
    input  rdata, freeze, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/assoc_cache_ctrl.sv
// 2-way set-associative, write-through, no-write-allocate data cache with per-set LRU.
// Optional read hit/miss counters are enabled by defining CACHE_STATS_EN.
module assoc_cache_ctrl #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned INDEX_W = 8,
  parameter int unsigned STAT_W  = 16
) (
  input logic              clk,
  input logic              rst,
  assoc_cache_ctrl_if.slave bus
`ifdef CACHE_STATS_EN
  ,
  output logic [STAT_W-1:0] hit_count,
  output logic [STAT_W-1:0] miss_count
`endif
);

  localparam int unsigned SETS  = 2 ** INDEX_W;
  localparam int unsigned TAG_W = ADDR_W - INDEX_W;

  if (ADDR_W <= INDEX_W || STAT_W < 1) begin : g_bad_cfg
    $error("assoc_cache_ctrl: tag width and STAT_W must both be at least 1");
  end

  typedef enum logic [1:0] {IDLE, RD_MISS, WR} state_t;

  state_t state;

  logic [SETS-1:0]   valid0, valid1, lru;
  logic [TAG_W-1:0]  tag0  [SETS];
  logic [TAG_W-1:0]  tag1  [SETS];
  logic [DATA_W-1:0] data0 [SETS];
  logic [DATA_W-1:0] data1 [SETS];

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic hit0, hit1, hit;
  logic victim;
  logic rd_hit, rd_fill, wr_done;

  assign idx = bus.addr[INDEX_W-1:0];
  assign tag = bus.addr[ADDR_W-1:INDEX_W];

  // Way0 takes priority if both ways somehow match.
  assign hit0 = valid0[idx] && (tag0[idx] == tag);
  assign hit1 = valid1[idx] && (tag1[idx] == tag) && !hit0;
  assign hit  = hit0 || hit1;

  assign victim = !valid0[idx] ? 1'b0 : (!valid1[idx] ? 1'b1 : lru[idx]);

  // A simultaneous rd_en/wr_en is a write, so reads are qualified by ~wr_en.
  assign rd_hit  = (state == IDLE) && bus.rd_en && !bus.wr_en && hit;
  assign rd_fill = (state == RD_MISS) && bus.mem_ready;
  assign wr_done = (state == WR) && bus.mem_ready;

  always_comb begin
    bus.freeze = ((state == IDLE) && (bus.wr_en || (bus.rd_en && !hit))) ||
                 ((state != IDLE) && !bus.mem_ready);
    bus.rdata  = '0;
    if (rd_hit)
      bus.rdata = hit0 ? data0[idx] : data1[idx];
    else if (rd_fill)
      bus.rdata = bus.mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      valid0        <= '0;
      valid1        <= '0;
      lru           <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
`ifdef CACHE_STATS_EN
      hit_count     <= '0;
      miss_count    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.wr_en) begin
            state         <= WR;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= bus.addr;
            bus.mem_wdata <= bus.wdata;
          end else if (bus.rd_en && !hit) begin
            state        <= RD_MISS;
            bus.mem_req  <= 1'b1;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= bus.addr;
          end else if (rd_hit) begin
            lru[idx] <= hit0;
`ifdef CACHE_STATS_EN
            if (hit_count != '1) hit_count <= hit_count + STAT_W'(1);
`endif
          end
        end
        RD_MISS: begin
          if (bus.mem_ready) begin
            state       <= IDLE;
            bus.mem_req <= 1'b0;
            if (victim) valid1[idx] <= 1'b1;
            else        valid0[idx] <= 1'b1;
            lru[idx] <= ~victim;
`ifdef CACHE_STATS_EN
            if (miss_count != '1) miss_count <= miss_count + STAT_W'(1);
`endif
          end
        end
        WR: begin
          if (bus.mem_ready) begin
            state       <= IDLE;
            bus.mem_req <= 1'b0;
            if (hit) lru[idx] <= hit0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag and data arrays carry no reset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (rd_fill) begin
      if (victim) begin
        tag1[idx]  <= tag;
        data1[idx] <= bus.mem_rdata;
      end else begin
        tag0[idx]  <= tag;
        data0[idx] <= bus.mem_rdata;
      end
    end else if (wr_done && hit) begin
      if (hit0) data0[idx] <= bus.wdata;
      else      data1[idx] <= bus.wdata;
    end
  end

endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// Directed bench for assoc_cache_ctrl: misses, hits, LRU replacement, writes, reset.
// With CACHE_STATS_EN a second instance with STAT_W=2 checks counter saturation.
module tb_assoc_cache_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned checks = 0;
  int unsigned passed = 0;

  always #5 clk = ~clk;

  assoc_cache_ctrl_if #(.ADDR_W(16), .DATA_W(16)) bus ();

`ifdef CACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
  logic [1:0]  sat_hit, sat_miss;
  assoc_cache_ctrl_if #(.ADDR_W(16), .DATA_W(16)) bus_sat ();

  assign bus_sat.rd_en     = bus.rd_en;
  assign bus_sat.wr_en     = bus.wr_en;
  assign bus_sat.addr      = bus.addr;
  assign bus_sat.wdata     = bus.wdata;
  assign bus_sat.mem_rdata = bus.mem_rdata;
  assign bus_sat.mem_ready = bus.mem_ready;

  assoc_cache_ctrl #(.ADDR_W(16), .DATA_W(16), .INDEX_W(8), .STAT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus), .hit_count(hit_count), .miss_count(miss_count)
  );
  assoc_cache_ctrl #(.ADDR_W(16), .DATA_W(16), .INDEX_W(8), .STAT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .bus(bus_sat), .hit_count(sat_hit), .miss_count(sat_miss)
  );
`else
  assoc_cache_ctrl #(.ADDR_W(16), .DATA_W(16), .INDEX_W(8), .STAT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    else
      passed++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Read miss; mem_ready is returned in cycle k (k >= 1) after the request cycle.
  task automatic read_miss(input logic [15:0] a, input logic [15:0] d, input int unsigned k);
    bus.rd_en = 1'b1; bus.addr = a;
    #1 check("miss_freeze0", bus.freeze, 1);
    step();
    check("miss_req", bus.mem_req, 1);
    check("miss_we", bus.mem_we, 0);
    check("miss_addr", bus.mem_addr, a);
    check("miss_freeze1", bus.freeze, 1);
    for (int unsigned i = 1; i < k; i++) step();
    bus.mem_ready = 1'b1; bus.mem_rdata = d;
    #1 check("miss_freeze_k", bus.freeze, 0);
    check("miss_rdata", bus.rdata, d);
    step();
    bus.mem_ready = 1'b0; bus.rd_en = 1'b0;
    #1 check("miss_req_clr", bus.mem_req, 0);
  endtask

  task automatic read_hit(input logic [15:0] a, input logic [15:0] exp);
    bus.rd_en = 1'b1; bus.addr = a;
    #1 check("hit_freeze", bus.freeze, 0);
    check("hit_rdata", bus.rdata, exp);
    step();
    bus.rd_en = 1'b0;
  endtask

  // Drives a read only combinationally, withdrawn before the edge.
  task automatic probe(input string tag, input logic [15:0] a, input logic exp_freeze);
    bus.rd_en = 1'b1; bus.addr = a;
    #1 check(tag, bus.freeze, exp_freeze);
    bus.rd_en = 1'b0;
    #1;
  endtask

  task automatic write(input logic [15:0] a, input logic [15:0] d, input int unsigned k,
                       input logic also_rd);
    bus.wr_en = 1'b1; bus.rd_en = also_rd; bus.addr = a; bus.wdata = d;
    #1 check("wr_freeze0", bus.freeze, 1);
    check("wr_rdata0", bus.rdata, 0);
    step();
    check("wr_req", bus.mem_req, 1);
    check("wr_we", bus.mem_we, 1);
    check("wr_addr", bus.mem_addr, a);
    check("wr_wdata", bus.mem_wdata, d);
    for (int unsigned i = 1; i < k; i++) step();
    bus.mem_ready = 1'b1; bus.mem_rdata = 16'hFFFF;
    #1 check("wr_freeze_k", bus.freeze, 0);
    step();
    bus.mem_ready = 1'b0; bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    #1 check("wr_req_clr", bus.mem_req, 0);
  endtask

  initial begin
    bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.addr = '0; bus.wdata = '0;
    bus.mem_rdata = '0; bus.mem_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    #1;
    check("rst_freeze", bus.freeze, 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_req", bus.mem_req, 0);
    check("rst_we", bus.mem_we, 0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_wdata", bus.mem_wdata, 0);

    // Basic miss then hit
    read_miss(16'h1234, 16'hBEEF, 3);
    read_hit(16'h1234, 16'hBEEF);

    // Set 0x05: LRU replacement
    read_miss(16'h0105, 16'hA105, 2);   // way0, lru=1
    read_miss(16'h0205, 16'hA205, 1);   // way1, lru=0
    read_hit(16'h0105, 16'hA105);       // lru=1
    read_miss(16'h0305, 16'hA305, 2);   // evicts way1 (0x0205), lru=0
    probe("evicted_0205", 16'h0205, 1);
    read_hit(16'h0105, 16'hA105);
    read_hit(16'h0305, 16'hA305);

    // Write hit updates, write miss does not allocate
    write(16'h0105, 16'h1111, 2, 1'b0);
    read_hit(16'h0105, 16'h1111);
    write(16'h0407, 16'h2222, 1, 1'b0);
    probe("no_alloc_0407", 16'h0407, 1);
    write(16'h1234, 16'h7777, 1, 1'b1);
    read_hit(16'h1234, 16'h7777);

    // Reset during an outstanding read miss
    bus.rd_en = 1'b1; bus.addr = 16'h0609;
    #1 check("rm_freeze0", bus.freeze, 1);
    step();
    check("rm_req", bus.mem_req, 1);
    rst = 1'b1; bus.rd_en = 1'b0;
    step();
    rst = 1'b0;
    #1 check("rm_req_clr", bus.mem_req, 0);
    check("rm_freeze", bus.freeze, 0);
    bus.mem_ready = 1'b1; bus.mem_rdata = 16'hDEAD;
    #1 check("stray_freeze", bus.freeze, 0);
    check("stray_rdata", bus.rdata, 0);
    step();
    bus.mem_ready = 1'b0;
    #1 check("stray_req", bus.mem_req, 0);
    probe("rst_invalid_1234", 16'h1234, 1);
`ifdef CACHE_STATS_EN
    check("rst_hit_cnt", hit_count, 0);
    check("rst_miss_cnt", miss_count, 0);
`endif

    // Statistics: 2 misses, then hits
    read_miss(16'h1234, 16'h5A5A, 1);
    read_miss(16'h0609, 16'h0609, 2);
    read_hit(16'h1234, 16'h5A5A);
    read_hit(16'h0609, 16'h0609);
    read_hit(16'h1234, 16'h5A5A);
`ifdef CACHE_STATS_EN
    check("hit_cnt3", hit_count, 3);
    check("miss_cnt2", miss_count, 2);
    check("sat_hit3", sat_hit, 3);
    check("sat_miss2", sat_miss, 2);
`endif
    read_hit(16'h1234, 16'h5A5A);
    read_hit(16'h0609, 16'h0609);
`ifdef CACHE_STATS_EN
    check("hit_cnt5", hit_count, 5);
    check("sat_hit_sat", sat_hit, 3);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
